fifo_port_arbiter: RTL and testbench

Access controller for the 16x4 FIFO datapath (write_pointer/read_pointer/memory_array/status_signal). Shares the single FIFO write port between two requesters with fair round-robin arbitration and a req/ack handshake. Sequences multi-entry burst reads (one entry per clock) on behalf of one consumer. Sits between requester logic and the FIFO's wr/rd strobes; consumes the FIFO's full/empty status.

---
 rtl/fifo_port_arbiter_if.sv | 22 ++
 rtl/fifo_port_arbiter.sv | 66 ++++++
 tb/tb_fifo_port_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_port_arbiter_if.sv
// fifo_port_arbiter_if: write-port handshakes, burst-read control and FIFO status/strobes
// shared between requesters, the arbiter and the FIFO datapath.
interface fifo_port_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int LEN_W  = 4
);
    logic              req0, req1, ack0, ack1;
    logic [DATA_W-1:0] data0, data1, fifo_wdata;
    logic              rd_req, rd_busy, rd_done;
    logic [LEN_W-1:0]  rd_len, rd_count;
    logic              fifo_full, fifo_empty, fifo_we, fifo_rd, last_grant;

    modport master (
        output req0, data0, req1, data1, rd_req, rd_len, fifo_full, fifo_empty,
        input  ack0, ack1, rd_busy, rd_done, rd_count, fifo_we, fifo_wdata, fifo_rd, last_grant
    );

    modport slave (
        input  req0, data0, req1, data1, rd_req, rd_len, fifo_full, fifo_empty,
        output ack0, ack1, rd_busy, rd_done, rd_count, fifo_we, fifo_wdata, fifo_rd, last_grant
    );
endinterface

// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter: round-robin arbitration of the FIFO write port between two requesters
// and a one-entry-per-clock burst read sequencer for a single consumer.
module fifo_port_arbiter #(
    parameter int DATA_W = 4,
    parameter int LEN_W  = 4
) (
    input logic               clk,
    input logic               rst_n,
    fifo_port_arbiter_if.slave port_if
);
    typedef enum logic [1:0] {IDLE, BURST, DONE} rd_state_e;

    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d, cnt_q, cnt_d;
    logic             rr_q, last_q, gnt0, gnt1;

    // Grants are gated by rst_n so the write strobes stay low while reset is held.
    assign gnt0 = rst_n & ~port_if.fifo_full & port_if.req0 & (~port_if.req1 | ~rr_q);
    assign gnt1 = rst_n & ~port_if.fifo_full & port_if.req1 & (~port_if.req0 | rr_q);

    assign port_if.ack0       = gnt0;
    assign port_if.ack1       = gnt1;
    assign port_if.fifo_we    = gnt0 | gnt1;
    assign port_if.fifo_wdata = gnt1 ? port_if.data1 : port_if.data0;
    assign port_if.last_grant = last_q;
    assign port_if.rd_count   = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= 1'b0;
            last_q  <= 1'b0;
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (gnt0 | gnt1) begin
                rr_q   <= gnt0;
                last_q <= gnt1;
            end
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rem_d           = rem_q;
        cnt_d           = cnt_q;
        port_if.rd_busy = state_q == BURST;
        port_if.rd_done = state_q == DONE;
        port_if.fifo_rd = (state_q == BURST) & ~port_if.fifo_empty;
        if (state_q == IDLE && port_if.rd_req && |port_if.rd_len) begin
            state_d = BURST;
            rem_d   = port_if.rd_len;
            cnt_d   = '0;
        end else if (state_q == BURST) begin
            // An empty FIFO ends the burst early, keeping the partial count.
            state_d = (port_if.fifo_empty || rem_q == LEN_W'(1)) ? DONE : BURST;
            rem_d   = port_if.fifo_empty ? rem_q : rem_q - LEN_W'(1);
            cnt_d   = port_if.fifo_empty ? cnt_q : cnt_q + LEN_W'(1);
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb_fifo_port_arbiter: vector table for write arbitration, directed burst/reset sequences,
// then randomized traffic checked against a behavioural model.
module tb_fifo_port_arbiter;
    localparam int DW = 4;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_port_arbiter_if #(.DATA_W(DW), .LEN_W(LW)) bus ();
    fifo_port_arbiter #(.DATA_W(DW), .LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .port_if(bus));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req0 = 0; bus.data0 = 0; bus.req1 = 0; bus.data1 = 0;
        bus.rd_req = 0; bus.rd_len = 0; bus.fifo_full = 0; bus.fifo_empty = 0;
    endtask

    typedef struct {
        logic          r0;
        logic [DW-1:0] d0;
        logic          r1;
        logic [DW-1:0] d1;
        logic          full;
        logic          we, a0, a1;
        logic [DW-1:0] wd;
        logic          lg;
    } wvec_t;

    wvec_t tbl[12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Vectors run back to back from reset, so rr pointer starts at requester 0.
        tbl[0]  = '{1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0};
        tbl[1]  = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1};
        tbl[2]  = '{1'b1, 4'h3, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0};
        tbl[3]  = '{1'b1, 4'h5, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 1'b1};
        tbl[4]  = '{1'b1, 4'h7, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 1'b0};
        tbl[5]  = '{1'b1, 4'h9, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 1'b0};
        tbl[6]  = '{1'b1, 4'hB, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 1'b0};
        tbl[7]  = '{1'b1, 4'hC, 1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 1'b1, 4'hD, 1'b1};
        tbl[8]  = '{1'b0, 4'hE, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b1};
        tbl[9]  = '{1'b0, 4'h4, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1};
        tbl[10] = '{1'b0, 4'h5, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 1'b1};
        tbl[11] = '{1'b1, 4'h8, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 1'b0};

        clear_inputs();
        bus.req0 = 1;
        #3;
        chk("rst_we", bus.fifo_we, 0);
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_busy", bus.rd_busy, 0);
        chk("rst_done", bus.rd_done, 0);
        chk("rst_count", bus.rd_count, 0);
        chk("rst_lg", bus.last_grant, 0);
        chk("rst_rd", bus.fifo_rd, 0);
        bus.req0 = 0;
        tick();
        rst_n = 1;

        for (int i = 0; i < 12; i++) begin
            bus.req0 = tbl[i].r0; bus.data0 = tbl[i].d0;
            bus.req1 = tbl[i].r1; bus.data1 = tbl[i].d1;
            bus.fifo_full = tbl[i].full;
            #4;
            chk($sformatf("tbl%0d_we", i), bus.fifo_we, int'(tbl[i].we));
            chk($sformatf("tbl%0d_ack0", i), bus.ack0, int'(tbl[i].a0));
            chk($sformatf("tbl%0d_ack1", i), bus.ack1, int'(tbl[i].a1));
            chk($sformatf("tbl%0d_wdata", i), bus.fifo_wdata, int'(tbl[i].wd));
            tick();
            chk($sformatf("tbl%0d_lg", i), bus.last_grant, int'(tbl[i].lg));
        end
        clear_inputs();

        // Full-length burst from a non-empty FIFO.
        bus.rd_req = 1; bus.rd_len = 5;
        #4 chk("b5_idle_busy", bus.rd_busy, 0);
        tick();
        bus.rd_req = 0;
        for (int k = 0; k < 5; k++) begin
            #4;
            chk($sformatf("b5_rd%0d", k), bus.fifo_rd, 1);
            chk($sformatf("b5_busy%0d", k), bus.rd_busy, 1);
            chk($sformatf("b5_done%0d", k), bus.rd_done, 0);
            tick();
        end
        #4;
        chk("b5_done", bus.rd_done, 1);
        chk("b5_busy_off", bus.rd_busy, 0);
        chk("b5_rd_off", bus.fifo_rd, 0);
        chk("b5_count", bus.rd_count, 5);
        tick();
        #4;
        chk("b5_done_pulse", bus.rd_done, 0);
        chk("b5_count_hold", bus.rd_count, 5);
        tick();

        // Burst cut short when the FIFO empties after three reads.
        bus.rd_req = 1; bus.rd_len = 6;
        tick();
        bus.rd_req = 0;
        for (int k = 0; k < 3; k++) begin
            #4 chk($sformatf("b6_rd%0d", k), bus.fifo_rd, 1);
            tick();
        end
        bus.fifo_empty = 1;
        #4;
        chk("b6_empty_rd", bus.fifo_rd, 0);
        chk("b6_empty_busy", bus.rd_busy, 1);
        tick();
        #4;
        chk("b6_done", bus.rd_done, 1);
        chk("b6_count", bus.rd_count, 3);
        tick();
        bus.fifo_empty = 0; bus.rd_req = 1; bus.rd_len = 0;
        tick();
        bus.rd_req = 0;
        #4;
        chk("len0_busy", bus.rd_busy, 0);
        chk("len0_rd", bus.fifo_rd, 0);
        chk("len0_count", bus.rd_count, 3);
        tick();

        // Reset in the middle of a burst while a write is also proceeding.
        bus.rd_req = 1; bus.rd_len = 8; bus.req0 = 1; bus.data0 = 4'h5;
        tick();
        bus.rd_req = 0;
        for (int k = 0; k < 2; k++) begin
            #4;
            chk($sformatf("b8_rd%0d", k), bus.fifo_rd, 1);
            chk($sformatf("b8_we%0d", k), bus.fifo_we, 1);
            tick();
        end
        #2 chk("b8_rd_pre", bus.fifo_rd, 1);
        rst_n = 0;
        #1;
        chk("mrst_rd", bus.fifo_rd, 0);
        chk("mrst_busy", bus.rd_busy, 0);
        chk("mrst_count", bus.rd_count, 0);
        chk("mrst_done", bus.rd_done, 0);
        chk("mrst_we", bus.fifo_we, 0);
        #2 rst_n = 1;
        bus.req0 = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            #4;
            chk($sformatf("mrst_nodone%0d", k), bus.rd_done, 0);
            chk($sformatf("mrst_idle%0d", k), bus.rd_busy, 0);
            tick();
        end

        // Randomized traffic against the model, starting from a fresh reset.
        rst_n = 0;
        #3 rst_n = 1;
        tick();
        begin
            int prio = 0, lg = 0, left = 0, cnt = 0, g;
            bit reading = 0, done_now = 0, nd;
            for (int c = 0; c < 400; c++) begin
                bus.req0 = 1'($urandom_range(0, 1));
                bus.req1 = 1'($urandom_range(0, 1));
                bus.data0 = 4'($urandom);
                bus.data1 = 4'($urandom);
                bus.fifo_full = ($urandom_range(0, 4) == 0);
                bus.fifo_empty = ($urandom_range(0, 5) == 0);
                bus.rd_req = ($urandom_range(0, 3) == 0);
                bus.rd_len = 4'($urandom_range(0, 15));
                #4;
                g = bus.fifo_full ? -1 : (bus.req0 && bus.req1) ? prio :
                    bus.req0 ? 0 : bus.req1 ? 1 : -1;
                chk("rnd_we", bus.fifo_we, int'(g >= 0));
                chk("rnd_ack0", bus.ack0, int'(g == 0));
                chk("rnd_ack1", bus.ack1, int'(g == 1));
                chk("rnd_wdata", bus.fifo_wdata, g == 1 ? int'(bus.data1) : int'(bus.data0));
                chk("rnd_lg", bus.last_grant, lg);
                chk("rnd_rd", bus.fifo_rd, int'(reading && !bus.fifo_empty));
                chk("rnd_busy", bus.rd_busy, int'(reading));
                chk("rnd_done", bus.rd_done, int'(done_now));
                chk("rnd_count", bus.rd_count, cnt);
                if (g >= 0) begin
                    prio = 1 - g;
                    lg = g;
                end
                nd = 0;
                if (reading) begin
                    if (bus.fifo_empty) begin
                        reading = 0;
                        nd = 1;
                    end else begin
                        cnt++;
                        left--;
                        if (left == 0) begin
                            reading = 0;
                            nd = 1;
                        end
                    end
                end else if (!done_now && bus.rd_req && bus.rd_len != 0) begin
                    reading = 1;
                    left = int'(bus.rd_len);
                    cnt = 0;
                end
                done_now = nd;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
